// File: rtl/data_cache_if.sv
// Load/store port from the MEM stage and block port to data_memory, bundled for the L1 data cache.
// slave = cache side, master = pipeline/memory side.
interface data_cache_if;
  logic         read;
  logic         write;
  logic [2:0]   funct3;
  logic [31:0]  address;
  logic [31:0]  write_data;
  logic [31:0]  read_data;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport slave (
    input  read, write, funct3, address, write_data, mem_readdata, mem_busywait,
    output read_data, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output read, write, funct3, address, write_data, mem_readdata, mem_busywait,
    input  read_data, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate L1 D-cache: hits return in the same cycle with no stall;
// misses hold busywait high through an optional dirty writeback and a block refill.
module data_cache #(
  parameter int INDEX_BITS = 3
) (
  input logic        clock,
  input logic        reset,
  data_cache_if.slave bus
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]    valid, dirty;
  logic [TAG_BITS-1:0] tag_arr  [LINES];
  logic [127:0]        data_arr [LINES];

  logic [3:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  access, hit, load_hit, store_hit, refill_done;
  logic [127:0]          line, line_st;
  logic [31:0]           sel_word;
  logic [15:0]           sel_half;
  logic [7:0]            sel_byte;

  assign offset = bus.address[3:0];
  assign index  = bus.address[3+INDEX_BITS:4];
  assign tag    = bus.address[31:4+INDEX_BITS];

  assign access      = bus.read ^ bus.write;
  assign hit         = valid[index] && (tag_arr[index] == tag);
  assign load_hit    = !reset && (state == IDLE) && bus.read && !bus.write && hit;
  assign store_hit   = !reset && (state == IDLE) && bus.write && !bus.read && hit;
  assign refill_done = (state == ALLOCATE) && !bus.mem_busywait;

  assign line     = data_arr[index];
  assign sel_word = line[{offset[3:2], 5'b0} +: 32];
  assign sel_half = line[{offset[3:1], 4'b0} +: 16];
  assign sel_byte = line[{offset, 3'b0} +: 8];

  always_comb begin
    bus.read_data = '0;
    if (load_hit) begin
      case (bus.funct3)
        3'b000:  bus.read_data = {{24{sel_byte[7]}}, sel_byte};
        3'b001:  bus.read_data = {{16{sel_half[15]}}, sel_half};
        3'b100:  bus.read_data = {24'b0, sel_byte};
        3'b101:  bus.read_data = {16'b0, sel_half};
        default: bus.read_data = sel_word;
      endcase
    end
  end

  // Store merge: funct3[1:0] gives the access width, the offset picks the lane.
  always_comb begin
    line_st = line;
    case (bus.funct3[1:0])
      2'b00:   line_st[{offset, 3'b0} +: 8]         = bus.write_data[7:0];
      2'b01:   line_st[{offset[3:1], 4'b0} +: 16]   = bus.write_data[15:0];
      default: line_st[{offset[3:2], 5'b0} +: 32]   = bus.write_data;
    endcase
  end

  always_comb begin
    state_nxt         = state;
    bus.busywait      = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (access && !hit) begin
            bus.busywait = 1'b1;
            state_nxt    = (valid[index] && dirty[index]) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          bus.busywait      = 1'b1;
          bus.mem_write     = 1'b1;
          bus.mem_address   = {tag_arr[index], index};
          bus.mem_writedata = line;
          if (!bus.mem_busywait) state_nxt = ALLOCATE;
        end
        ALLOCATE: begin
          bus.busywait    = 1'b1;
          bus.mem_read    = 1'b1;
          bus.mem_address = {tag, index};
          if (!bus.mem_busywait) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_nxt;
      if (refill_done) begin
        valid[index] <= 1'b1;
        dirty[index] <= 1'b0;
      end else if (store_hit) begin
        dirty[index] <= 1'b1;
      end
    end
  end

  // Line payload and tags need no reset; valid gates every use of them.
  always_ff @(posedge clock) begin
    if (refill_done && !reset) begin
      data_arr[index] <= bus.mem_readdata;
      tag_arr[index]  <= tag;
    end else if (store_hit) begin
      data_arr[index] <= line_st;
    end
  end
endmodule
